// File: rtl/snake_pkg.sv
// Shared direction types and helpers for the snake input path.
// Consumed by input_conditioner and button_debouncer.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam dir_t RESET_HEADING = DIR_RIGHT;

  function automatic dir_t opposite(dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/input_conditioner_button_debouncer.sv
// Single-button two-flop synchronizer followed by a hold-time debouncer.
// The stable level only changes after DEBOUNCE_CYCLES consecutive mismatches.
import snake_pkg::*;

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o
);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      stable_d = sync_q[1];
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// Button conditioning plus a 2-entry direction queue for the snake core.
// Define INPUT_REVERSAL_FILTER_EN to also drop presses opposite the reference.
import snake_pkg::*;

module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_btn,
  input  logic       i_consume,
  output logic [3:0] o_btn_level,
  output logic [3:0] o_press,
  output logic       o_dir_valid,
  output logic [1:0] o_dir,
  output logic       o_overflow
);

  logic [3:0] level;
  logic [3:0] prev_q;
  logic [3:0] press_q;
  logic       ovf_q, ovf_d;
  dir_t       mem_q [2];
  logic       head_q;
  logic [1:0] cnt_q, cnt_d;
  dir_t       heading_q;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (i_btn[g]),
      .level_o(level[g])
    );
  end

  dir_t sel;
  dir_t ref_dir;
  logic sel_vld;
  logic drop;
  logic push, pop, full, accept;
  logic wr_idx;

  always_comb begin
    sel = DIR_RIGHT;
    priority case (1'b1)
      press_q[0]: sel = DIR_UP;
      press_q[1]: sel = DIR_DOWN;
      press_q[2]: sel = DIR_LEFT;
      default:    sel = DIR_RIGHT;
    endcase
  end

  // Tail sits one slot past head only when both entries are live.
  assign ref_dir = (cnt_q != 2'd0) ? mem_q[head_q ^ cnt_q[1]] : heading_q;
  assign sel_vld = |press_q;

`ifdef INPUT_REVERSAL_FILTER_EN
  assign drop = (sel == ref_dir) || (sel == opposite(ref_dir));
`else
  assign drop = (sel == ref_dir);
`endif

  assign push   = sel_vld && !drop;
  assign pop    = i_consume && (cnt_q != 2'd0);
  assign full   = (cnt_q == 2'd2);
  assign accept = push && (!full || pop);
  assign ovf_d  = push && full && !pop;
  assign wr_idx = head_q ^ cnt_q[0];
  assign cnt_d  = cnt_q + {1'b0, accept} - {1'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '0;
      press_q   <= '0;
      ovf_q     <= 1'b0;
      mem_q[0]  <= RESET_HEADING;
      mem_q[1]  <= RESET_HEADING;
      head_q    <= 1'b0;
      cnt_q     <= 2'd0;
      heading_q <= RESET_HEADING;
    end else begin
      prev_q  <= level;
      press_q <= level & ~prev_q;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      if (accept) mem_q[wr_idx] <= sel;
      if (pop) begin
        heading_q <= mem_q[head_q];
        head_q    <= ~head_q;
      end
    end
  end

  assign o_btn_level = level;
  assign o_press     = press_q;
  assign o_overflow  = ovf_q;
  assign o_dir_valid = (cnt_q != 2'd0);
  assign o_dir       = (cnt_q != 2'd0) ? mem_q[head_q] : heading_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=4.
// Press/overflow pulses and queue-state changes are checked by a monitor.
module tb_input_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] i_btn;
  logic       i_consume;
  logic [3:0] o_btn_level;
  logic [3:0] o_press;
  logic       o_dir_valid;
  logic [1:0] o_dir;
  logic       o_overflow;

  int errors = 0;
  int checks = 0;

  logic [4:0] exp_ev [$];
  logic [2:0] exp_q  [$];
  logic [2:0] last_q;

  input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_btn      (i_btn),
    .i_consume  (i_consume),
    .o_btn_level(o_btn_level),
    .o_press    (o_press),
    .o_dir_valid(o_dir_valid),
    .o_dir      (o_dir),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows a pulse or queue change
  initial begin
    logic [4:0] e;
    logic [2:0] s;
    last_q = 3'b011;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_q = 3'b011;
      end else begin
        if (o_press != 4'd0 || o_overflow) begin
          checks++;
          if (exp_ev.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse got=%0h exp=none",
                     {o_press, o_overflow});
          end else begin
            e = exp_ev.pop_front();
            if ({o_press, o_overflow} !== e) begin
              errors++;
              $display("FAIL pulse got=%0h exp=%0h",
                       {o_press, o_overflow}, e);
            end
          end
        end
        s = {o_dir_valid, o_dir};
        if (s !== last_q) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_qstate got=%0h exp=none", s);
          end else begin
            e = {2'b00, exp_q.pop_front()};
            if (s !== e[2:0]) begin
              errors++;
              $display("FAIL qstate got=%0h exp=%0h", s, e[2:0]);
            end
          end
          last_q = s;
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_btn = 4'd0;
    i_consume = 1'b0;
    tick(2);
    chk("rst_level", o_btn_level, 4'd0);
    chk("rst_press", o_press, 4'd0);
    chk("rst_valid", o_dir_valid, 1'b0);
    chk("rst_dir", o_dir, 2'd3);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("rst_pending", exp_ev.size() + exp_q.size(), 0);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic press(logic [3:0] m);
    i_btn = m;
    tick(10);
    i_btn = 4'd0;
    tick(12);
  endtask

  task automatic consume();
    i_consume = 1'b1;
    tick(1);
    i_consume = 1'b0;
    tick(2);
  endtask

  initial begin
    rst = 1'b1;
    i_btn = 4'd0;
    i_consume = 1'b0;
    #2;
    do_reset();

    // Clean press latency
    exp_ev.push_back(5'b0001_0);
    exp_q.push_back(3'b1_00);
    i_btn = 4'b0001;
    tick(5);
    chk("lat_level5", o_btn_level, 4'd0);
    tick(1);
    chk("lat_level6", o_btn_level, 4'b0001);
    chk("lat_press6", o_press, 4'd0);
    tick(1);
    chk("lat_press7", o_press, 4'b0001);
    chk("lat_valid7", o_dir_valid, 1'b0);
    tick(1);
    chk("lat_valid8", o_dir_valid, 1'b1);
    chk("lat_dir8", o_dir, 2'd0);
    chk("lat_press8", o_press, 4'd0);
    tick(2);
    i_btn = 4'd0;
    tick(12);
    exp_q.push_back(3'b0_00);
    consume();

    // Bounce on left; heading is up
    exp_ev.push_back(5'b0100_0);
    exp_q.push_back(3'b1_10);
    for (int k = 0; k < 10; k++) begin
      i_btn = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      tick(2);
    end
    chk("bounce_nolevel", o_btn_level, 4'd0);
    i_btn = 4'b0100;
    tick(10);
    chk("bounce_level", o_btn_level, 4'b0100);
    i_btn = 4'd0;
    tick(12);
    exp_q.push_back(3'b0_10);
    consume();

    // Simultaneous up+left; heading is left
    exp_ev.push_back(5'b0101_0);
    exp_q.push_back(3'b1_00);
    press(4'b0101);
    chk("simul_dir", o_dir, 2'd0);
    exp_q.push_back(3'b0_00);
    consume();
    consume();
    chk("empty_consume_valid", o_dir_valid, 1'b0);
    chk("empty_consume_dir", o_dir, 2'd0);

    // Full queue and overflow
    do_reset();
    exp_ev.push_back(5'b0010_0);
    exp_q.push_back(3'b1_01);
    press(4'b0010);
    exp_ev.push_back(5'b0100_0);
    press(4'b0100);
    chk("full_head", o_dir, 2'd1);
    exp_ev.push_back(5'b0001_0);
    exp_ev.push_back(5'b0000_1);
    press(4'b0001);
    chk("ovf_head", o_dir, 2'd1);
    chk("ovf_valid", o_dir_valid, 1'b1);
    exp_ev.push_back(5'b0001_0);
    exp_q.push_back(3'b1_10);
    i_btn = 4'b0001;
    tick(7);
    chk("pp_press", o_press, 4'b0001);
    i_consume = 1'b1;
    tick(1);
    i_consume = 1'b0;
    chk("pp_head", o_dir, 2'd2);
    chk("pp_ovf", o_overflow, 1'b0);
    tick(2);
    i_btn = 4'd0;
    tick(12);
    exp_q.push_back(3'b1_00);
    consume();
    exp_q.push_back(3'b0_00);
    consume();

    // Reversal against reset heading (right)
    do_reset();
    exp_ev.push_back(5'b0100_0);
`ifdef INPUT_REVERSAL_FILTER_EN
    press(4'b0100);
    chk("rev_valid", o_dir_valid, 1'b0);
    chk("rev_dir", o_dir, 2'd3);
`else
    exp_q.push_back(3'b1_10);
    press(4'b0100);
    chk("rev_valid", o_dir_valid, 1'b1);
    chk("rev_dir", o_dir, 2'd2);
`endif

    // Async reset with two entries and a debounce in flight
    do_reset();
    exp_ev.push_back(5'b0010_0);
    exp_q.push_back(3'b1_01);
    press(4'b0010);
    exp_ev.push_back(5'b0100_0);
    i_btn = 4'b0100;
    tick(10);
    chk("ar_level_before", o_btn_level, 4'b0100);
    i_btn = 4'b1100;
    tick(4);
    rst = 1'b1;
    #1;
    chk("ar_level", o_btn_level, 4'd0);
    chk("ar_press", o_press, 4'd0);
    chk("ar_valid", o_dir_valid, 1'b0);
    chk("ar_dir", o_dir, 2'd3);
    chk("ar_ovf", o_overflow, 1'b0);
    i_btn = 4'd0;
    tick(2);
    rst = 1'b0;
    tick(3);

    chk("left_ev", exp_ev.size(), 0);
    chk("left_q", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Conditions the four raw direction buttons before they reach the game core. It synchronizes and debounces each button, then turns rising edges into one-cycle press pulses. Presses feed a 2-entry direction queue that the game drains once per snake step, so quick double-taps between steps are kept rather than lost. The block sits between the board pins (up/down/left/right buttons) and the game's direction inputs, in the VGA pixel-clock domain.

## Interface
- DEBOUNCE_CYCLES, default 250000: cycles a synchronized level must hold before it is accepted (≈10 ms at 25.175 MHz); legal range ≥ 2.
- CNT_W, default $clog2(DEBOUNCE_CYCLES): debounce counter width; derived, not overridden.

Ports:
- clk  in  1  pixel clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_btn  in  4  raw buttons, bit0 up, bit1 down, bit2 left, bit3 right; asynchronous to clk.
- i_consume  in  1  game takes the head direction this cycle (one snake step).
- o_btn_level  out  4  debounced button levels.
- o_press  out  4  one-cycle pulse per debounced rising edge.
- o_dir_valid  out  1  queue non-empty.
- o_dir  out  2  head of queue: 0 up, 1 down, 2 left, 3 right; holds the last popped heading when empty.
- o_overflow  out  1  one-cycle pulse when a press is dropped because the queue is full.

## Operation
- Synchronizer: two flops per button, reset 0.
- Debounce, per button:
  - stable register and counter, both reset 0.
  - When sync == stable, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable <= sync and the counter clears.
  - Any bounce back to the stable value before terminal count restarts the count from 0.
- Edge detect: o_press[i] = stable[i] rose this cycle, registered.
- Direction select: if several o_press bits are set in one cycle, only the highest priority is enqueued. Priority order is up > down > left > right.
- Queue: 2 entries, circular, with count register 0..2.
  - Push when a selected press exists and is not filtered.
  - Pop when i_consume && count != 0.
  - Push and pop in the same cycle:
    - count 2: the pop frees a slot and the push is accepted; count stays 2.
    - count 1: count stays 1 and the head advances to the new entry.
    - count 0: the push is accepted and the pop is ignored; count becomes 1.
  - Push while full without a pop: the press is dropped and o_overflow pulses.
  - i_consume while empty: no effect.
- Duplicate suppression: a push equal to the reference direction is dropped silently. The reference direction is the tail entry if count != 0, otherwise heading.
- heading register: updated with the popped value on each pop; reset value 3 (right).
- o_dir = head entry when count != 0, else heading.
- Reset mid-operation (async): all state returns to reset values immediately, including queue, counters and heading.

## Timing
- Reset values: o_btn_level 0, o_press 0, o_dir_valid 0, o_dir 3, o_overflow 0.
- Latency from a clean pin edge:
  - 2 cycles through the synchronizer.
  - DEBOUNCE_CYCLES cycles to stable.
  - o_press 1 cycle after stable.
  - o_dir_valid/o_dir 1 cycle after o_press.
- Pop is visible on o_dir the cycle after i_consume.
- o_press and o_overflow are exactly one cycle wide.

## Configuration
- INPUT_REVERSAL_FILTER_EN defined:
  - A push whose direction equals reference ^ 2'b01 (the exact opposite) is also dropped silently.
  - This prevents the snake from reversing into itself.
- Undefined: opposite directions are queued normally; only duplicates are suppressed.

## Structure
- Shared package (snake_pkg): dir_t enum (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3), the RESET_HEADING constant, and an opposite() function (xor 1).
- One sub-module, button_debouncer (synchronizer + counter + stable register for a single bit, parameterized by DEBOUNCE_CYCLES), instantiated 4×.
- Queue, priority select and filter live in the top.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Clean press: i_btn[0] held high → o_btn_level[0] high 6 cycles later; o_press[0] one pulse at 7; o_dir_valid=1, o_dir=0 at 8.
- Bounce: i_btn[2] toggles every 2 cycles for 20 cycles, then holds 1 → no o_press until 4 stable cycles; exactly one press[2] results, queue gets 2.
- Simultaneous: up+left pressed in the same cycle → only dir 0 is enqueued; count=1.
- Full queue: enqueue down, left; press up with no consume → o_overflow pulses and the queue still holds 1, 2. Repeat the press with i_consume in the same cycle → head 2, tail 0, count 2.
- Reversal: after reset (heading 3), press left. With INPUT_REVERSAL_FILTER_EN defined: no enqueue, o_dir_valid stays 0. Without the macro: enqueued, o_dir=2.
- Async reset with count=2 mid-debounce → all outputs return to reset values within the same cycle; o_dir=3.
